mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped countdown timer that acts as a bus responder to the CPU's load/store port. It occupies a 16-byte window beside data memory. The CPU writes CTRL/PRESET with word/half/byte stores and reads CTRL/PRESET/COUNT with word loads. An internal FSM counts COUNT down to zero and raises a maskable interrupt in one-shot or auto-reload mode.

## Interface
- BASE_ADDR, 32'h00007F00, byte address of the register window; bits [3:0] must be 0.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- addr  in  32  CPU data address (ALU result).
- wdata  in  32  store data, already lane-aligned by the CPU.
- we  in  1  store strobe; meaningful only when hit==1.
- be  in  4  byte enables for stores: be[i] writes byte i (bits 8i+7:8i); 4'b1111 for sw.
- hit  out  1  combinational; addr falls inside a valid register of the window.
- rdata  out  32  combinational read data; 0 when hit==0.
- irq  out  1  interrupt request, irq = IRQ_FLAG & CTRL.IM.

## Operation
- Register map (offset = addr[3:0], addr[1:0] ignored):
  - 0x0 CTRL: [0] EN, [2:1] MODE, [3] IM, [31:4] read 0 and write-ignored.
  - 0x4 PRESET: 32-bit R/W.
  - 0x8 COUNT: read-only.
  - 0xC: unmapped, hit=0.
- hit = (addr[31:4]==BASE_ADDR[31:4]) && (addr[3:2]!=2'b11).
- Writes to COUNT are ignored. Writes with we=0 or hit=0 are ignored.
- MODE: 2'b00 one-shot; 2'b01 auto-reload; 2'b1x is treated as one-shot.
- Any write to CTRL or PRESET (any be≠0) clears IRQ_FLAG, unless the FSM sets it in the same cycle; set wins.
- FSM states: IDLE, CNT, INT.
  - IDLE: COUNT holds. If EN==1, then COUNT<=PRESET and go to CNT.
  - CNT: if EN==0, go to IDLE and COUNT holds. Else if COUNT<=1, then COUNT<=0 and go to INT. Else COUNT<=COUNT-1.
  - INT, one-shot: IRQ_FLAG<=1, EN<=0, go to IDLE. IRQ_FLAG stays high until cleared by a CTRL/PRESET write.
  - INT, auto-reload: IRQ_FLAG<=1, COUNT<=PRESET, go to CNT. In CNT, IRQ_FLAG clears on the next edge, so the pulse is exactly 1 cycle.
- Priority:
  - A bus write to CTRL.EN beats the FSM's EN clear in INT.
  - A PRESET write during CNT affects only the next load; the current count is unaffected.
  - Clearing EN mid-count freezes COUNT. Re-enabling reloads COUNT from PRESET.
- Arithmetic: 32-bit unsigned decrement; no wrap below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, IRQ_FLAG=0, state=IDLE, irq=0. rdata=0 unless hit.
- Reads are zero-latency (combinational from addr), as needed for the single-cycle datapath. Writes take effect at the same edge that commits the store.
- If EN is written at edge N with PRESET=P≥1:
  - COUNT=P after edge N+1.
  - COUNT=0 and state INT after edge N+1+P.
  - IRQ_FLAG=1 after edge N+2+P.
- P=0 behaves like P=1: flag set after edge N+3.
- Auto-reload period is P+1 cycles between flag pulses (P≥1).
- Reset asserted mid-count: returns to reset values at that edge. The counter does not resume after release.

## Test plan
- Reset, then read 0x7F00/0x7F04/0x7F08 -> all 0, irq=0; read 0x7F0C -> hit=0, rdata=0.
- Write PRESET=5, then CTRL=4'b1001 (EN, one-shot, IM) at edge N -> COUNT reads 5,4,3,2,1,0 after edges N+1..N+6; irq=1 after N+7; CTRL reads 8 (EN cleared); irq stays 1 until a CTRL write, then 0.
- Write PRESET=3, CTRL=4'b1011 (auto-reload) -> irq pulses 1 cycle wide every 4 cycles; COUNT sequence 3,2,1,0,3,2,...
- During counting, write CTRL=0 at COUNT=7 -> COUNT holds 7 indefinitely; write CTRL=1 -> COUNT reloads PRESET next edge.
- sb of 8'hAB to 0x7F05 with be=4'b0010 on PRESET=0 -> PRESET reads 32'h0000AB00; sw to 0x7F08 -> COUNT unchanged.
- Same-cycle CTRL write (IM=1, EN=0) and FSM entering INT one-shot -> IRQ_FLAG=1 (set wins), EN=0, irq=1.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer
//   Memory-mapped countdown timer responding to the CPU load/store port.
//   A 16-byte register window at BASE_ADDR holds CTRL, PRESET and COUNT.
//   A three-state FSM counts COUNT down to zero and raises an interrupt
//   flag, either once (one-shot) or periodically (auto-reload).
//
// Ports
//   clk    in   system clock, all state changes on the rising edge
//   reset  in   synchronous active-low reset
//   addr   in   32-bit CPU data address
//   wdata  in   32-bit lane-aligned store data
//   we     in   store strobe, meaningful only when hit is high
//   be     in   4-bit byte enables for stores
//   hit    out  addr selects a mapped register of the window (comb.)
//   rdata  out  read data, zero when hit is low (comb.)
//   irq    out  IRQ_FLAG & CTRL.IM
//
// Register map (offset addr[3:2])
//   0x0 CTRL   [0] EN, [2:1] MODE, [3] IM, upper bits read 0
//   0x4 PRESET 32-bit R/W
//   0x8 COUNT  read-only
//   0xC unmapped

module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  be,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_hit;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_bus_clr_flag;
  logic        w_auto;

  logic [31:0] w_count_nxt;
  logic        w_fsm_set_flag;
  logic        w_fsm_clr_flag;
  logic        w_fsm_clr_en;

  // Byte-lane select bits are not needed by word-granular decoding.
  logic        w_unused;
  assign w_unused = ^addr[1:0];

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  assign w_hit = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
  assign hit   = w_hit;

  always_comb begin
    rdata = '0;
    if (w_hit) begin
      case (addr[3:2])
        2'b00:   rdata = {28'b0, r_im, r_mode, r_en};
        2'b01:   rdata = r_preset;
        2'b10:   rdata = r_count;
        default: rdata = '0;
      endcase
    end
  end

  assign w_wr           = we && w_hit;
  assign w_wr_ctrl      = w_wr && (addr[3:2] == 2'b00);
  assign w_wr_preset    = w_wr && (addr[3:2] == 2'b01);
  assign w_bus_clr_flag = (w_wr_ctrl || w_wr_preset) && (be != 4'b0000);

  // Only MODE 2'b01 reloads; 2'b00 and 2'b1x both behave as one-shot.
  assign w_auto = (r_mode == 2'b01);

  assign irq = r_irq_flag && r_im;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, next count and flag/enable side effects
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_fsm_set_flag = 1'b0;
    w_fsm_clr_flag = 1'b0;
    w_fsm_clr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_count_nxt = r_preset;
          w_state_nxt = S_CNT;
        end
      end
      S_CNT: begin
        // The reload pulse from INT lasts exactly one cycle in auto mode.
        if (w_auto) begin
          w_fsm_clr_flag = 1'b1;
        end
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count <= 32'd1) begin
          w_count_nxt = '0;
          w_state_nxt = S_INT;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
      S_INT: begin
        w_fsm_set_flag = 1'b1;
        if (w_auto) begin
          w_count_nxt = r_preset;
          w_state_nxt = S_CNT;
        end else begin
          w_fsm_clr_en = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // A bus write of CTRL byte 0 overrides the FSM clearing EN in INT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_mode <= 2'b00;
      r_im   <= 1'b0;
    end else begin
      if (w_wr_ctrl && be[0]) begin
        r_en   <= wdata[0];
        r_mode <= wdata[2:1];
        r_im   <= wdata[3];
      end else if (w_fsm_clr_en) begin
        r_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          r_preset[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // The FSM setting the flag beats any clear from the bus or CNT state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_flag <= 1'b0;
    end else if (w_fsm_set_flag) begin
      r_irq_flag <= 1'b1;
    end else if (w_bus_clr_flag || w_fsm_clr_flag) begin
      r_irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  be;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_HOLE   = 32'h0000_7F0C;

  mmio_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .be    (be),
    .hit   (hit),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store committed at the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    wdata = d;
    be    = b;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    be    = 4'b0000;
    wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic chk_hit(input string tag, input logic [31:0] a, input logic exp);
    addr = a;
    #1;
    chk(tag, {31'b0, hit}, {31'b0, exp});
  endtask

  initial begin
    reset = 1'b0;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    be    = 4'b0000;
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_preset", A_PRESET, 32'h0);
    rd("rst_count", A_COUNT, 32'h0);
    chk_irq("rst_irq", 1'b0);
    chk_hit("hit_ctrl", A_CTRL, 1'b1);
    chk_hit("hit_count", A_COUNT, 1'b1);
    chk_hit("hit_hole", A_HOLE, 1'b0);
    rd("hole_rdata", A_HOLE, 32'h0);
    chk_hit("hit_outside", 32'h0000_7F10, 1'b0);
    chk_hit("hit_below", 32'h0000_6F00, 1'b0);

    // One-shot, PRESET=5, IM=1
    wr(A_PRESET, 32'd5, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);            // edge N
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd($sformatf("os_count_%0d", k), A_COUNT, 32'(6 - k));
      chk_irq($sformatf("os_irq_lo_%0d", k), 1'b0);
    end
    tick();                                // N+7
    chk_irq("os_irq_set", 1'b1);
    rd("os_ctrl_en_clr", A_CTRL, 32'h8);
    rd("os_count_hold", A_COUNT, 32'h0);
    tick();
    tick();
    chk_irq("os_irq_sticky", 1'b1);
    wr(A_CTRL, 32'h8, 4'b1111);
    chk_irq("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=3
    wr(A_PRESET, 32'd3, 4'b1111);
    wr(A_CTRL, 32'hB, 4'b1111);            // edge N
    begin
      logic [31:0] exp_cnt [9];
      logic        exp_irq [9];
      exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 9; k++) begin
        tick();
        rd($sformatf("ar_count_%0d", k + 1), A_COUNT, exp_cnt[k]);
        chk_irq($sformatf("ar_irq_%0d", k + 1), exp_irq[k]);
      end
    end
    wr(A_CTRL, 32'h0, 4'b1111);            // count 3 -> 2, EN off
    tick();
    rd("ar_stop_count", A_COUNT, 32'd2);
    chk_irq("ar_stop_irq", 1'b0);

    // Freeze mid-count and re-enable
    wr(A_PRESET, 32'd10, 4'b1111);
    wr(A_CTRL, 32'h1, 4'b1111);            // edge N
    tick();
    tick();
    tick();                                // N+3
    rd("fz_count_8", A_COUNT, 32'd8);
    wr(A_CTRL, 32'h0, 4'b1111);            // count lands at 7 with EN off
    rd("fz_count_7", A_COUNT, 32'd7);
    for (int k = 0; k < 5; k++) tick();
    rd("fz_count_hold", A_COUNT, 32'd7);
    wr(A_COUNT, 32'h1234_5678, 4'b1111);
    rd("fz_count_ro", A_COUNT, 32'd7);
    wr(A_CTRL, 32'h1, 4'b1111);            // edge E
    rd("fz_reen_e", A_COUNT, 32'd7);
    tick();                                // E+1
    rd("fz_reload", A_COUNT, 32'd10);
    wr(A_CTRL, 32'h0, 4'b1111);
    tick();

    // Byte store and CTRL upper bits
    wr(A_PRESET, 32'h0, 4'b1111);
    wr(32'h0000_7F05, 32'h0000_AB00, 4'b0010);
    rd("sb_preset", A_PRESET, 32'h0000_AB00);
    wr(A_PRESET, 32'hFFFF_FFFF, 4'b0000);
    rd("be0_preset", A_PRESET, 32'h0000_AB00);
    wr(A_CTRL, 32'hFFFF_FFF0, 4'b1111);
    rd("ctrl_hi_zero", A_CTRL, 32'h0);

    // CTRL write coinciding with INT one-shot: flag set wins
    wr(A_PRESET, 32'd2, 4'b1111);
    wr(A_CTRL, 32'h1, 4'b1111);            // edge N
    tick();
    tick();
    tick();                                // N+3: COUNT=0, state INT
    rd("sc_count_0", A_COUNT, 32'd0);
    chk_irq("sc_irq_pre", 1'b0);
    wr(A_CTRL, 32'h8, 4'b1111);            // edge N+4
    chk_irq("sc_irq_set", 1'b1);
    rd("sc_ctrl", A_CTRL, 32'h8);

    // MODE 2'b11 behaves as one-shot, P=0 behaves as P=1
    wr(A_PRESET, 32'd0, 4'b1111);
    wr(A_CTRL, 32'hF, 4'b1111);            // edge N
    tick();
    tick();
    chk_irq("m3_irq_lo", 1'b0);
    tick();                                // N+3
    chk_irq("m3_irq_set", 1'b1);
    rd("m3_ctrl_en_clr", A_CTRL, 32'hE);

    // Reset mid-count
    wr(A_PRESET, 32'd20, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd("mr_count", A_COUNT, 32'h0);
    rd("mr_ctrl", A_CTRL, 32'h0);
    rd("mr_preset", A_PRESET, 32'h0);
    chk_irq("mr_irq", 1'b0);
    tick();
    tick();
    tick();
    rd("mr_no_resume", A_COUNT, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
